pipe_stage_skid: RTL and testbench

- Parametrised elastic pipeline-stage register, the successor to the fixed ID/EX-style stage registers.
- Carries a control bundle and a data payload between CPU pipeline stages using a valid/ready handshake instead of free-running capture.
- Supports downstream stall through backpressure, optional 2-entry skid buffering for full throughput with a registered ready, and synchronous flush.
- Flush and drain insert a bubble by zeroing the control bundle.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_entry_reg.sv | 51 +++++
 rtl/pipe_stage_skid.sv | 180 ++++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage.
// Occupancy states, drop counter width, ID/EX field widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  localparam int DROP_CNT_W = 8;

  localparam int PC_W   = 32;
  localparam int INST_W = 32;
  localparam int IMM_W  = 32;
  localparam int RD1_W  = 32;
  localparam int RD2_W  = 32;
  localparam int WREG_W = 5;

endpackage

// File: rtl/pipe_entry_reg.sv
// One valid+ctrl+data holding register of the stage.
// Ports: clk, i_reset, i_load, i_clear_ctrl, i_clear_data, i_ctrl,
// i_data in; o_valid, o_ctrl, o_data out.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 133
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic              i_clear_ctrl,
  input  logic              i_clear_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  // Clearing wins over loading so a kill can never be overridden.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else begin
      if (i_clear_ctrl) begin
        r_valid <= 1'b0;
        r_ctrl  <= '0;
      end else if (i_load) begin
        r_valid <= 1'b1;
        r_ctrl  <= i_ctrl;
      end
      if (i_clear_data)
        r_data <= '0;
      else if (i_load && !i_clear_ctrl)
        r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic valid/ready pipeline stage, optional 2-entry skid buffer.
// Ports: clk, reset, flush, in_* upstream, out_* downstream, occupancy, flush_drops.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W     = 16,
  parameter int DATA_W     = 133,
  parameter bit SKID       = 1'b1,
  parameter bit FLUSH_DATA = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_W-1:0]     in_ctrl,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [DATA_W-1:0]     out_data,
  output logic [1:0]            occupancy,
  output logic [DROP_CNT_W-1:0] flush_drops
);

  localparam int CW = DROP_CNT_W + 1;

  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_m_load;
  logic              w_m_clr;
  logic              w_m_clr_d;
  logic [CTRL_W-1:0] w_m_ctrl_d;
  logic [DATA_W-1:0] w_m_data_d;
  logic              w_m_valid;
  logic [CTRL_W-1:0] w_m_ctrl;
  logic [DATA_W-1:0] w_m_data;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = w_m_valid & out_ready;

  pipe_entry_reg #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W)
  ) u_main (
    .clk          (clk),
    .i_reset      (reset),
    .i_load       (w_m_load),
    .i_clear_ctrl (w_m_clr),
    .i_clear_data (w_m_clr_d),
    .i_ctrl       (w_m_ctrl_d),
    .i_data       (w_m_data_d),
    .o_valid      (w_m_valid),
    .o_ctrl       (w_m_ctrl),
    .o_data       (w_m_data)
  );

  assign out_valid = w_m_valid;
  assign out_ctrl  = w_m_ctrl;
  assign out_data  = w_m_data;

  if (SKID) begin : g_skid
    pipe_state_e       r_state;
    pipe_state_e       w_next;
    logic              r_in_ready;
    logic              w_s_load;
    logic              w_s_clr;
    logic              w_s_valid;
    logic [CTRL_W-1:0] w_s_ctrl;
    logic [DATA_W-1:0] w_s_data;

    // in_ready is a pure flop: it looks ahead at the next state.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_state    <= ST_EMPTY;
        r_in_ready <= 1'b1;
      end else begin
        r_state    <= w_next;
        r_in_ready <= (w_next != ST_TWO);
      end
    end

    always_comb begin
      w_next = r_state;
      if (flush) begin
        w_next = ST_EMPTY;
      end else begin
        unique case (r_state)
          ST_EMPTY:
            if (w_in_fire) w_next = ST_ONE;
          ST_ONE:
            if (w_in_fire && !w_out_fire)
              w_next = ST_TWO;
            else if (!w_in_fire && w_out_fire)
              w_next = ST_EMPTY;
          ST_TWO:
            if (w_out_fire) w_next = ST_ONE;
          default: w_next = ST_EMPTY;
        endcase
      end
    end

    always_comb begin
      w_m_load   = 1'b0;
      w_m_clr    = 1'b0;
      w_s_load   = 1'b0;
      w_s_clr    = 1'b0;
      w_m_ctrl_d = in_ctrl;
      w_m_data_d = in_data;
      if (flush) begin
        w_m_clr = 1'b1;
        w_s_clr = 1'b1;
      end else begin
        unique case (r_state)
          ST_EMPTY: w_m_load = w_in_fire;
          ST_ONE: begin
            w_m_load = w_in_fire & w_out_fire;
            w_s_load = w_in_fire & ~w_out_fire;
            w_m_clr  = ~w_in_fire & w_out_fire;
          end
          ST_TWO: begin
            w_m_load   = w_out_fire;
            w_s_clr    = w_out_fire;
            w_m_ctrl_d = w_s_ctrl;
            w_m_data_d = w_s_data;
          end
          default: ;
        endcase
      end
      w_m_clr_d = flush & FLUSH_DATA;
    end

    pipe_entry_reg #(
      .CTRL_W(CTRL_W),
      .DATA_W(DATA_W)
    ) u_skid (
      .clk          (clk),
      .i_reset      (reset),
      .i_load       (w_s_load),
      .i_clear_ctrl (w_s_clr),
      .i_clear_data (flush & FLUSH_DATA),
      .i_ctrl       (in_ctrl),
      .i_data       (in_data),
      .o_valid      (w_s_valid),
      .o_ctrl       (w_s_ctrl),
      .o_data       (w_s_data)
    );

    logic w_unused;
    assign w_unused  = w_s_valid;
    assign in_ready  = r_in_ready;
    assign occupancy = r_state;
  end else begin : g_flat
    assign in_ready   = ~w_m_valid | out_ready;
    assign w_m_load   = w_in_fire & ~flush;
    assign w_m_clr    = flush | (w_out_fire & ~w_in_fire);
    assign w_m_clr_d  = flush & FLUSH_DATA;
    assign w_m_ctrl_d = in_ctrl;
    assign w_m_data_d = in_data;
    assign occupancy  = {1'b0, w_m_valid};
  end

  logic [DROP_CNT_W-1:0] r_drops;
  logic [CW-1:0]         w_drop_sum;

  // A beat leaving downstream in the flush cycle is not a drop.
  assign w_drop_sum = {1'b0, r_drops} + CW'(occupancy)
                    + CW'(w_in_fire) - CW'(w_out_fire);

  always_ff @(posedge clk) begin
    if (reset)
      r_drops <= '0;
    else if (flush)
      r_drops <= w_drop_sum[DROP_CNT_W] ? '1
               : w_drop_sum[DROP_CNT_W-1:0];
  end

  assign flush_drops = r_drops;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: three configurations share stimulus,
// each checked against a FIFO reference model.
module tb_pipe_stage_skid;

  localparam int CW = 16;
  localparam int DW = 133;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_ready;

  logic          o_rdy   [3];
  logic          o_valid [3];
  logic [CW-1:0] o_ctrl  [3];
  logic [DW-1:0] o_data  [3];
  logic [1:0]    o_occ   [3];
  logic [7:0]    o_drops [3];

  int n_err = 0;
  int n_chk = 0;

  // Model: per-DUT FIFO contents, last payload seen, drop count.
  logic [DW-1:0] m_qd   [3][2];
  logic [CW-1:0] m_qc   [3][2];
  int            m_cnt  [3];
  int            m_drops[3];
  logic [DW-1:0] m_last [3];

  always #5 clk = ~clk;

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1), .FLUSH_DATA(1'b1)) u_d0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(o_rdy[0]), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(o_valid[0]), .out_ready(out_ready), .out_ctrl(o_ctrl[0]),
    .out_data(o_data[0]), .occupancy(o_occ[0]), .flush_drops(o_drops[0]));

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0), .FLUSH_DATA(1'b1)) u_d1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(o_rdy[1]), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(o_valid[1]), .out_ready(out_ready), .out_ctrl(o_ctrl[1]),
    .out_data(o_data[1]), .occupancy(o_occ[1]), .flush_drops(o_drops[1]));

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1), .FLUSH_DATA(1'b0)) u_d2 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(o_rdy[2]), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(o_valid[2]), .out_ready(out_ready), .out_ctrl(o_ctrl[2]),
    .out_data(o_data[2]), .occupancy(o_occ[2]), .flush_drops(o_drops[2]));

  task automatic chk(input int d, input string tag,
                     input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[dut%0d] observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rdata();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_cnt[d]   = 0;
      m_drops[d] = 0;
      m_last[d]  = '0;
    end
  endtask

  // One clock: drive, check current outputs at negedge, advance model.
  task automatic step(input logic iv, input logic [CW-1:0] ic,
                      input logic [DW-1:0] idt, input logic ordy,
                      input logic fl, input logic rs);
    logic er;
    logic ifire;
    logic ofire;
    int   nd;
    in_valid  = iv;
    in_ctrl   = ic;
    in_data   = idt;
    out_ready = ordy;
    flush     = fl;
    reset     = rs;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      er = (d == 1) ? (m_cnt[d] == 0 || ordy) : (m_cnt[d] < 2);
      chk(d, "in_ready", DW'(o_rdy[d]), DW'(er));
      chk(d, "out_valid", DW'(o_valid[d]), DW'(m_cnt[d] > 0));
      chk(d, "out_ctrl", DW'(o_ctrl[d]),
          m_cnt[d] > 0 ? DW'(m_qc[d][0]) : '0);
      chk(d, "out_data", o_data[d],
          m_cnt[d] > 0 ? m_qd[d][0] : m_last[d]);
      chk(d, "occupancy", DW'(o_occ[d]), DW'(m_cnt[d]));
      chk(d, "flush_drops", DW'(o_drops[d]), DW'(m_drops[d]));
      ifire = iv & er;
      ofire = ordy & (m_cnt[d] > 0);
      if (rs) begin
        m_cnt[d]   = 0;
        m_drops[d] = 0;
        m_last[d]  = '0;
      end else if (fl) begin
        nd = m_drops[d] + m_cnt[d] - int'(ofire) + int'(ifire);
        m_drops[d] = (nd > 255) ? 255 : nd;
        if (d == 2)
          m_last[d] = (m_cnt[d] > 0) ? m_qd[d][0] : m_last[d];
        else
          m_last[d] = '0;
        m_cnt[d] = 0;
      end else begin
        if (ofire) begin
          m_last[d]  = m_qd[d][0];
          m_qd[d][0] = m_qd[d][1];
          m_qc[d][0] = m_qc[d][1];
          m_cnt[d]--;
        end
        if (ifire) begin
          m_qd[d][m_cnt[d]] = idt;
          m_qc[d][m_cnt[d]] = ic;
          m_cnt[d]++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    for (int d = 0; d < 3; d++) begin
      chk(d, "rst_in_ready", DW'(o_rdy[d]), DW'(1));
      chk(d, "rst_data", o_data[d], '0);
    end
    step(0, '0, '0, 0, 0, 0);

    // Streaming 0x1..0xA with downstream always ready
    for (int i = 1; i <= 10; i++)
      step(1, CW'($urandom), DW'(i), 1, 0, 0);
    chk(0, "stream_last", o_data[0], DW'(10));
    step(0, '0, '0, 1, 0, 0);

    // Backpressure: four stalled cycles, then release
    step(1, 16'h0011, DW'(1), 0, 0, 0);
    step(1, 16'h0022, DW'(2), 0, 0, 0);
    chk(0, "bp_occ2", DW'(o_occ[0]), DW'(2));
    step(1, 16'h0033, DW'(3), 0, 0, 0);
    step(1, 16'h0033, DW'(3), 0, 0, 0);
    chk(0, "bp_head", o_data[0], DW'(1));
    for (int i = 0; i < 5; i++)
      step(1, 16'h0033, DW'(3), 1, 0, 0);
    step(0, '0, '0, 1, 0, 0);
    step(0, '0, '0, 1, 0, 0);

    // Flush with a full stage and a beat on the input
    step(0, '0, '0, 0, 0, 1);
    step(1, 16'h00AA, DW'(5), 0, 0, 0);
    step(1, 16'h00BB, DW'(6), 0, 0, 0);
    step(1, 16'hFFFF, DW'(7), 0, 1, 0);
    chk(0, "fl_valid", DW'(o_valid[0]), '0);
    chk(0, "fl_ctrl", DW'(o_ctrl[0]), '0);
    chk(0, "fl_data", o_data[0], '0);
    chk(0, "fl_drops", DW'(o_drops[0]), DW'(2));
    step(0, '0, '0, 0, 0, 0);

    // Flush keeps payload when FLUSH_DATA=0
    step(1, 16'h0F0F, DW'(16'hDEAD), 0, 0, 0);
    step(0, '0, '0, 0, 1, 0);
    chk(2, "fd0_data", o_data[2], DW'(16'hDEAD));
    chk(0, "fd1_data", o_data[0], '0);
    step(0, '0, '0, 1, 0, 0);

    // Toggling downstream ready over 20 offered beats
    for (int i = 0; i < 20; i++)
      step(1, CW'(i + 1), DW'(32'h100 + i), ~i[0], 0, 0);
    for (int i = 0; i < 3; i++)
      step(0, '0, '0, 1, 0, 0);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 3) != 0, CW'($urandom), rdata(),
           $urandom_range(0, 2) != 0, $urandom_range(0, 30) == 0,
           $urandom_range(0, 250) == 0);

    // Drop counter saturation
    step(0, '0, '0, 0, 0, 1);
    for (int i = 0; i < 300; i++) begin
      step(1, CW'($urandom), rdata(), 0, 0, 0);
      step(0, '0, '0, 0, 1, 0);
    end
    for (int d = 0; d < 3; d++)
      chk(d, "drops_sat", DW'(o_drops[d]), DW'(255));

    // Reset mid-transfer clears everything
    step(1, 16'h1234, rdata(), 0, 0, 0);
    step(1, 16'h5678, rdata(), 0, 0, 1);
    for (int d = 0; d < 3; d++) begin
      chk(d, "rst2_drops", DW'(o_drops[d]), '0);
      chk(d, "rst2_valid", DW'(o_valid[d]), '0);
      chk(d, "rst2_data", o_data[d], '0);
    end
    step(0, '0, '0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
